// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid geometry, state encoding and LFSR constants
package snake_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL       = 16;
  localparam int CELL_SHIFT = $clog2(CELL);
  localparam int SCREEN_W   = GRID_W * CELL;
  localparam int SCREEN_H   = GRID_H * CELL;
  localparam int NUM_CELLS  = GRID_W * GRID_H;
  localparam int CX_W       = $clog2(GRID_W);
  localparam int CY_W       = $clog2(GRID_H);

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_GEN    = 3'd0,
    ST_QUERY  = 3'd1,
    ST_SCAN   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_IDLE   = 3'd4,
    ST_WIN    = 3'd5
  } spawn_state_t;

  // Row-major successor of a cell, wrapping at the right edge and the bottom row.
  function automatic logic [CY_W+CX_W-1:0] next_cell(input logic [CX_W-1:0] x,
                                                     input logic [CY_W-1:0] y);
    logic [CX_W-1:0] nx;
    logic [CY_W-1:0] ny;
    if (x == CX_W'(GRID_W - 1)) begin
      nx = '0;
      ny = (y == CY_W'(GRID_H - 1)) ? '0 : y + 1'b1;
    end else begin
      nx = x + 1'b1;
      ny = y;
    end
    return {ny, nx};
  endfunction

endpackage

// File: rtl/apple_spawn_ctrl_if.sv
// rtl/apple_spawn_ctrl_if.sv - req/ack port to the shared occupancy checker
interface apple_spawn_ctrl_if;
  import snake_pkg::*;

  logic            occ_req;
  logic [CX_W-1:0] occ_x;
  logic [CY_W-1:0] occ_y;
  logic            occ_ack;
  logic            occ_hit;

  modport master (output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
  modport slave  (input occ_req, occ_x, occ_y, output occ_ack, occ_hit);

endinterface

// File: rtl/apple_lfsr16.sv
// rtl/apple_lfsr16.sv - free-running 16-bit Galois LFSR
module apple_lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  // Shift right every cycle, folding the output bit back through the taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/apple_spawn_ctrl.sv
// rtl/apple_spawn_ctrl.sv - apple placement and snake growth sequencer
module apple_spawn_ctrl
  import snake_pkg::*;
#(
  parameter int          INIT_SIZE = 3,
  parameter int          MAX_SIZE  = 255,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               in_update_clock,
  input  logic               in_reset,
  input  logic               in_eat,
  apple_spawn_ctrl_if.master occ,
  output logic [9:0]         out_appleX,
  output logic [8:0]         out_appleY,
  output logic               out_apple_valid,
  output logic [7:0]         out_snake_size,
  output logic               out_grow,
  output logic               out_win
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  spawn_state_t    state, state_n;
  logic [CX_W-1:0] cx, cx_n;
  logic [CY_W-1:0] cy, cy_n;
  logic [TRY_W-1:0] tries, tries_n;
  logic [10:0]     scan_cnt, scan_cnt_n;
  logic            req, req_n;
  logic [9:0]      apple_x_n;
  logic [8:0]      apple_y_n;
  logic            valid_n, grow_n, win_n;
  logic [7:0]      size_n;
  logic [15:0]     lfsr;
  logic [CX_W-1:0] cand_x;
  logic [CY_W-1:0] cand_y;
  logic [CY_W+CX_W-1:0] succ;
  logic            lfsr_unused;

  apple_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (in_update_clock),
    .rst_n (in_reset),
    .lfsr  (lfsr)
  );

  assign cand_x      = lfsr[5:0];
  assign cand_y      = lfsr[12:8];
  assign lfsr_unused = ^{lfsr[15:13], lfsr[7:6]};
  assign succ        = next_cell(cx, cy);

  assign occ.occ_req = req;
  assign occ.occ_x   = cx;
  assign occ.occ_y   = cy;

  // State and output registers; reset wins immediately, even mid-handshake.
  always_ff @(posedge in_update_clock or negedge in_reset) begin
    if (!in_reset) begin
      state           <= ST_GEN;
      cx              <= '0;
      cy              <= '0;
      tries           <= '0;
      scan_cnt        <= '0;
      req             <= 1'b0;
      out_appleX      <= '0;
      out_appleY      <= '0;
      out_apple_valid <= 1'b0;
      out_snake_size  <= 8'(INIT_SIZE);
      out_grow        <= 1'b0;
      out_win         <= 1'b0;
    end else begin
      state           <= state_n;
      cx              <= cx_n;
      cy              <= cy_n;
      tries           <= tries_n;
      scan_cnt        <= scan_cnt_n;
      req             <= req_n;
      out_appleX      <= apple_x_n;
      out_appleY      <= apple_y_n;
      out_apple_valid <= valid_n;
      out_snake_size  <= size_n;
      out_grow        <= grow_n;
      out_win         <= win_n;
    end
  end

  // Next-state logic: random probing, fallback linear scan, commit, and growth.
  always_comb begin
    state_n    = state;
    cx_n       = cx;
    cy_n       = cy;
    tries_n    = tries;
    scan_cnt_n = scan_cnt;
    req_n      = req;
    apple_x_n  = out_appleX;
    apple_y_n  = out_appleY;
    valid_n    = out_apple_valid;
    size_n     = out_snake_size;
    grow_n     = 1'b0;
    win_n      = out_win;

    case (state)
      ST_GEN: begin
        // Out-of-grid candidates are simply skipped; only real queries count as tries.
        if (cand_x < CX_W'(GRID_W) && cand_y < CY_W'(GRID_H)) begin
          cx_n    = cand_x;
          cy_n    = cand_y;
          req_n   = 1'b1;
          state_n = ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (!req) begin
          req_n = 1'b1;
        end else if (occ.occ_ack) begin
          req_n = 1'b0;
          if (!occ.occ_hit) begin
            state_n = ST_COMMIT;
          end else begin
            tries_n = tries + 1'b1;
            if (tries_n == TRY_W'(MAX_TRIES)) begin
              {cy_n, cx_n} = succ;
              state_n      = ST_SCAN;
            end else begin
              state_n = ST_GEN;
            end
          end
        end
      end
      ST_SCAN: begin
        // req is re-raised one cycle after each ack so every cell is a distinct handshake.
        if (!req) begin
          req_n = 1'b1;
        end else if (occ.occ_ack) begin
          req_n = 1'b0;
          if (!occ.occ_hit) begin
            state_n = ST_COMMIT;
          end else begin
            scan_cnt_n = scan_cnt + 11'd1;
            if (scan_cnt_n == 11'(NUM_CELLS)) begin
              state_n = ST_WIN;
            end else begin
              {cy_n, cx_n} = succ;
            end
          end
        end
      end
      ST_COMMIT: begin
        apple_x_n  = 10'(cx) << CELL_SHIFT;
        apple_y_n  = 9'(cy) << CELL_SHIFT;
        valid_n    = 1'b1;
        tries_n    = '0;
        scan_cnt_n = '0;
        state_n    = ST_IDLE;
      end
      ST_IDLE: begin
        if (in_eat) begin
          valid_n = 1'b0;
          grow_n  = 1'b1;
          size_n  = out_snake_size + 8'd1;
          state_n = (size_n == 8'(MAX_SIZE)) ? ST_WIN : ST_GEN;
        end
      end
      ST_WIN: begin
        state_n = ST_WIN;
      end
      default: begin
        state_n = ST_GEN;
      end
    endcase

    // Winning is terminal: no apple and no further occupancy traffic.
    if (state_n == ST_WIN) begin
      win_n   = 1'b1;
      valid_n = 1'b0;
      req_n   = 1'b0;
    end
  end

endmodule

// File: doc/apple_spawn_ctrl.md
Name: apple_spawn_ctrl

Overview:
Sequences apple placement and snake growth for the snake game. On an eat event it grows the snake, picks a random grid cell, and checks it against the snake body through a req/ack port to the shared occupancy checker. It retries until a free cell is found, then publishes the apple position to the renderer.
It sits between the collision/movement logic and the VGA draw path, and replaces the free-running apple update.

Parameters:
GRID_W, 40, grid columns (640 px / CELL)
GRID_H, 30, grid rows (480 px / CELL)
CELL, 16, cell size in pixels (power of two)
INIT_SIZE, 3, snake length after reset
MAX_SIZE, 255, length at which the game is won
MAX_TRIES, 8, random queries before falling back to linear scan
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
in_update_clock  in  1  game update clock, all logic rising-edge
in_reset  in  1  asynchronous, active-low reset
in_eat  in  1  single-cycle pulse: snake head entered apple cell
in_occ_ack  in  1  occupancy checker response valid
in_occ_hit  in  1  1 = queried cell occupied by snake (valid with ack)
out_occ_req  out  1  occupancy query request
out_occ_x  out  6  queried cell column
out_occ_y  out  5  queried cell row
out_appleX  out  10  apple pixel X (cell_x*CELL)
out_appleY  out  9  apple pixel Y (cell_y*CELL)
out_apple_valid  out  1  apple position is committed and drawable
out_snake_size  out  8  current snake length
out_grow  out  1  one-cycle pulse per accepted eat
out_win  out  1  sticky game-won flag

Behaviour:
- Reset (asynchronous, active-low; takes effect immediately, including mid-query):
  - state = GEN; LFSR = LFSR_SEED; tries = 0.
  - out_appleX/Y = 0, out_apple_valid = 0, out_snake_size = INIT_SIZE.
  - out_occ_req = 0, out_occ_x/y = 0, out_grow = 0, out_win = 0.
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle in every state.
- States: GEN, QUERY, SCAN, COMMIT, IDLE, WIN.
- GEN:
  - Candidate is x = lfsr[5:0], y = lfsr[12:8].
  - If x < GRID_W and y < GRID_H: latch the candidate and go to QUERY. Otherwise stay in GEN; an out-of-range candidate does not count as a try.
- QUERY / SCAN handshake:
  - out_occ_req goes high with out_occ_x/y stable and stays high until in_occ_ack is sampled high.
  - req drops on the edge that samples ack. Ack while req is low is ignored.
  - In_occ_hit is sampled only together with ack.
- QUERY result:
  - hit = 0 → COMMIT.
  - hit = 1 → tries+1. If tries == MAX_TRIES, enter SCAN starting at the next cell after the rejected one; otherwise go to GEN.
- SCAN:
  - Cell order is x+1, wrapping at GRID_W to x = 0, y+1; y wraps at GRID_H to 0.
  - One query per cell. hit = 0 → COMMIT.
  - A scan counter (11 bits) counts cells; GRID_W*GRID_H consecutive hits → WIN.
- COMMIT (1 cycle):
  - out_appleX = x*CELL, out_appleY = y*CELL (shift, zero-extended).
  - out_apple_valid = 1; tries and scan counter cleared → IDLE.
- IDLE: on in_eat:
  - out_apple_valid = 0 next cycle, out_grow = 1 for that one cycle.
  - out_snake_size + 1; if the new size == MAX_SIZE → WIN, else → GEN.
- in_eat is ignored outside IDLE: no grow, no size change.
- WIN: sticky until reset. out_win = 1, out_apple_valid = 0, no requests.
- Latency, with ack in the first req cycle: eat sampled at edge t, req high after t+1, ack sampled at t+2, valid high after t+3.
- Size never exceeds MAX_SIZE; no wrap of the 8-bit size.

Decomposition:
- snake_pkg: GRID_W, GRID_H, CELL, screen width/height, cell coordinate widths, state encoding constants, LFSR taps.
- Sub-module apple_lfsr16: free-running Galois LFSR with seed parameter and async active-low reset; its output is the 16-bit state.

Test Plan:
- Occupancy model always hit = 0, ack 1 cycle after req. Release reset →
  - out_apple_valid rises within 20 cycles;
  - appleX%16 == 0, appleX < 640, appleY%16 == 0, appleY < 480;
  - out_snake_size == 3.
- Five in_eat pulses spaced 50 cycles →
  - five one-cycle out_grow pulses, size == 8;
  - apple_valid drops the cycle after each eat and reasserts ≤ 4 cycles later with ack immediate;
  - no req while in IDLE.
- Model: hit = 1 everywhere except cell (0,0) →
  - exactly 8 random queries, then sequential scan queries;
  - final appleX = 0, appleY = 0, valid = 1.
- Model: all cells occupied → out_win = 1 after 8 + 1200 queries; apple_valid = 0; req stays low afterwards.
- Bench MAX_SIZE = 5 → second eat gives size 5 and out_win = 1; a third eat is ignored.
- Assert in_reset low while out_occ_req high and ack withheld → req, grow and valid drop immediately, size = 3. After release, a new spawn sequence completes normally.
- Eat pulse during GEN/QUERY → ignored; size unchanged.
